// File: rtl/operand_forward_stage.sv
// ID/EX pipeline stage: captures decode fields and register-file data into the
// EX register, forwards MEM/WB results onto the EX operands, and detects
// load-use hazards. On a load-use hazard it stalls ID and inserts one bubble.
module operand_forward_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // ID stage
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regWrite,
  input  logic             id_memRead,
  input  logic [PC_W-1:0]  id_pc,
  input  logic [XLEN-1:0]  rf_data1,
  input  logic [XLEN-1:0]  rf_data2,
  input  logic             flush,
  // MEM stage
  input  logic [4:0]       mem_rd,
  input  logic             mem_regWrite,
  input  logic [XLEN-1:0]  mem_result,
  // WB stage
  input  logic [4:0]       wb_rd,
  input  logic             wb_regWrite,
  input  logic [XLEN-1:0]  wb_data,
  // Hazard / EX outputs
  output logic             stall_id,
  output logic             ex_valid,
  output logic [4:0]       ex_rd,
  output logic             ex_regWrite,
  output logic             ex_memRead,
  output logic [PC_W-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_op1,
  output logic [XLEN-1:0]  ex_op2,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    FwdRf,
    FwdMem,
    FwdWb
  } fwd_sel_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  // EX pipeline register
  logic             ex_valid_q;
  logic [4:0]       ex_rd_q;
  logic             ex_regwrite_q;
  logic             ex_memread_q;
  logic [PC_W-1:0]  ex_pc_q;
  logic [4:0]       ex_rs1_q;
  logic [4:0]       ex_rs2_q;
  logic [XLEN-1:0]  ex_data1_q;
  logic [XLEN-1:0]  ex_data2_q;
  logic [CNT_W-1:0] stall_count_q;

  logic             load_use;
  logic             bubble;
  logic             count_en;
  fwd_sel_e         fwd1_sel;
  fwd_sel_e         fwd2_sel;

  // Load-use hazard: the load in EX produces rd only after MEM, too late for
  // the instruction in ID, so hold ID for one cycle. Independent of flush.
  always_comb begin
    load_use = 1'b0;
    if (ex_valid_q && ex_memread_q && (ex_rd_q != 5'd0) && id_valid) begin
      load_use = (id_rs1 == ex_rd_q) || (id_rs2 == ex_rd_q);
    end
  end

  assign stall_id = load_use;

  // Flush and stall both turn the next EX slot into a bubble; only a stall
  // that is not overridden by a flush is counted.
  always_comb begin
    bubble   = flush || load_use;
    count_en = load_use && !flush && (stall_count_q != CntMax);
  end

  // EX register capture; bubbles only clear the control bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_rd_q       <= 5'd0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_q      <= 5'd0;
      ex_rs2_q      <= 5'd0;
      ex_data1_q    <= '0;
      ex_data2_q    <= '0;
    end else if (bubble) begin
      ex_valid_q    <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
    end else begin
      ex_valid_q    <= id_valid;
      ex_rd_q       <= id_rd;
      ex_regwrite_q <= id_valid && id_regWrite;
      ex_memread_q  <= id_valid && id_memRead;
      ex_pc_q       <= id_pc;
      ex_rs1_q      <= id_rs1;
      ex_rs2_q      <= id_rs2;
      ex_data1_q    <= rf_data1;
      ex_data2_q    <= rf_data2;
    end
  end

  // Saturating load-use stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else if (count_en) begin
      stall_count_q <= stall_count_q + 1'b1;
    end
  end

  // Operand 1 source select: MEM is younger than WB so it wins; x0 never forwards
  always_comb begin
    fwd1_sel = FwdRf;
    if (mem_regWrite && (mem_rd != 5'd0) && (mem_rd == ex_rs1_q)) begin
      fwd1_sel = FwdMem;
    end else if (wb_regWrite && (wb_rd != 5'd0) && (wb_rd == ex_rs1_q)) begin
      fwd1_sel = FwdWb;
    end
  end

  // Operand 2 source select, same priority as operand 1
  always_comb begin
    fwd2_sel = FwdRf;
    if (mem_regWrite && (mem_rd != 5'd0) && (mem_rd == ex_rs2_q)) begin
      fwd2_sel = FwdMem;
    end else if (wb_regWrite && (wb_rd != 5'd0) && (wb_rd == ex_rs2_q)) begin
      fwd2_sel = FwdWb;
    end
  end

  // Operand 1 mux
  always_comb begin
    ex_op1 = ex_data1_q;
    unique case (fwd1_sel)
      FwdMem:  ex_op1 = mem_result;
      FwdWb:   ex_op1 = wb_data;
      default: ex_op1 = ex_data1_q;
    endcase
  end

  // Operand 2 mux
  always_comb begin
    ex_op2 = ex_data2_q;
    unique case (fwd2_sel)
      FwdMem:  ex_op2 = mem_result;
      FwdWb:   ex_op2 = wb_data;
      default: ex_op2 = ex_data2_q;
    endcase
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rd       = ex_rd_q;
  assign ex_regWrite = ex_regwrite_q;
  assign ex_memRead  = ex_memread_q;
  assign ex_pc       = ex_pc_q;
  assign stall_count = stall_count_q;

endmodule
